// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch controller: FSM state encoding and BCD field constants.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_PAUSED  = 2'd0,
        ST_RUNNING = 2'd1,
        ST_ADJUST  = 2'd2
    } state_t;

    localparam int unsigned DIGIT_W     = 4;
    localparam int unsigned FIELD_MAX   = 59;

endpackage

// File: rtl/bcd_mod60_counter.sv
// Two-digit BCD counter for one MM or SS field; wraps MAX_VAL -> 00 and flags the wrap.
module bcd_mod60_counter
    import stopwatch_pkg::*;
#(
    parameter int unsigned MAX_VAL = FIELD_MAX
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               inc,
    input  logic               clr,
    output logic [DIGIT_W-1:0] tens,
    output logic [DIGIT_W-1:0] ones,
    output logic               wrap
);

    localparam logic [DIGIT_W-1:0] TENS_MAX = DIGIT_W'(MAX_VAL / 10);
    localparam logic [DIGIT_W-1:0] ONES_MAX = DIGIT_W'(MAX_VAL % 10);

    logic [DIGIT_W-1:0] tens_q, tens_d;
    logic [DIGIT_W-1:0] ones_q, ones_d;
    logic               at_max;

    assign at_max = (tens_q == TENS_MAX) && (ones_q == ONES_MAX);
    // Same-cycle carry so the next field can step on the very edge this one wraps.
    assign wrap   = inc && at_max;

    always_comb begin
        tens_d = tens_q;
        ones_d = ones_q;
        if (clr) begin
            tens_d = '0;
            ones_d = '0;
        end else if (inc) begin
            if (at_max) begin
                tens_d = '0;
                ones_d = '0;
            end else if (ones_q == DIGIT_W'(9)) begin
                ones_d = '0;
                tens_d = tens_q + DIGIT_W'(1);
            end else begin
                ones_d = ones_q + DIGIT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tens_q <= '0;
            ones_q <= '0;
        end else begin
            tens_q <= tens_d;
            ones_q <= ones_d;
        end
    end

    assign tens = tens_q;
    assign ones = ones_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencing controller: run/pause/adjust FSM, MM:SS BCD registers, blink blanking.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int unsigned MAX_VAL        = FIELD_MAX,
    parameter bit          PAUSE_ON_RESET = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pause_pulse,
    input  logic       reset_pulse,
    input  logic       adj,
    input  logic       sel,
    input  logic       tick_1hz,
    input  logic       tick_2hz,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic [1:0] blank_mask,
    output logic       running
);

    state_t     state_q, state_d;
    logic       run_flag_q, run_flag_d;
    logic       blink_q, blink_d;
    logic [1:0] blank_q, blank_d;
    logic       running_q, running_d;

    logic       in_run, in_adj;
    logic       sec_inc, min_inc, sec_wrap, min_wrap;

    assign in_run = (state_q == ST_RUNNING);
    assign in_adj = (state_q == ST_ADJUST);

    assign sec_inc = (in_run && tick_1hz) || (in_adj && tick_2hz && sel);
    assign min_inc = (in_run && sec_wrap) || (in_adj && tick_2hz && !sel);

    always_comb begin
        run_flag_d = run_flag_q ^ pause_pulse;
        if (PAUSE_ON_RESET && reset_pulse)
            run_flag_d = 1'b0;

        state_d = state_q;
        unique case (state_q)
            ST_PAUSED:  state_d = adj ? ST_ADJUST : (run_flag_d ? ST_RUNNING : ST_PAUSED);
            ST_RUNNING: state_d = adj ? ST_ADJUST : (run_flag_d ? ST_RUNNING : ST_PAUSED);
            ST_ADJUST:  state_d = adj ? ST_ADJUST : (run_flag_q ? ST_RUNNING : ST_PAUSED);
            default:    state_d = ST_PAUSED;
        endcase

        // Phase restarts at 0 on every fresh entry into adjust.
        blink_d = 1'b0;
        if (in_adj)
            blink_d = blink_q ^ tick_2hz;

        blank_d = 2'b00;
        if (state_d == ST_ADJUST && blink_d)
            blank_d = sel ? 2'b01 : 2'b10;

        running_d = (state_d == ST_RUNNING);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_PAUSED;
            run_flag_q <= 1'b0;
            blink_q    <= 1'b0;
            blank_q    <= 2'b00;
            running_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            run_flag_q <= run_flag_d;
            blink_q    <= blink_d;
            blank_q    <= blank_d;
            running_q  <= running_d;
        end
    end

    bcd_mod60_counter #(.MAX_VAL(MAX_VAL)) u_sec (
        .clk  (clk),
        .rst  (rst),
        .inc  (sec_inc),
        .clr  (reset_pulse),
        .tens (sec_tens),
        .ones (sec_ones),
        .wrap (sec_wrap)
    );

    bcd_mod60_counter #(.MAX_VAL(MAX_VAL)) u_min (
        .clk  (clk),
        .rst  (rst),
        .inc  (min_inc),
        .clr  (reset_pulse),
        .tens (min_tens),
        .ones (min_ones),
        .wrap (min_wrap)
    );

    assign blank_mask = blank_q;
    assign running    = running_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl: vector table plus hand-written multi-cycle sequences.
module tb_stopwatch_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic pause_pulse = 1'b0, reset_pulse = 1'b0, adj = 1'b0, sel = 1'b0;
    logic tick_1hz = 1'b0, tick_2hz = 1'b0;

    logic [3:0] mt0, mo0, st0, so0, mt1, mo1, st1, so1;
    logic [1:0] bm0, bm1;
    logic       run0, run1;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    stopwatch_ctrl #(.MAX_VAL(59), .PAUSE_ON_RESET(1'b0)) dut0 (
        .clk(clk), .rst(rst), .pause_pulse(pause_pulse), .reset_pulse(reset_pulse),
        .adj(adj), .sel(sel), .tick_1hz(tick_1hz), .tick_2hz(tick_2hz),
        .min_tens(mt0), .min_ones(mo0), .sec_tens(st0), .sec_ones(so0),
        .blank_mask(bm0), .running(run0)
    );

    stopwatch_ctrl #(.MAX_VAL(59), .PAUSE_ON_RESET(1'b1)) dut1 (
        .clk(clk), .rst(rst), .pause_pulse(pause_pulse), .reset_pulse(reset_pulse),
        .adj(adj), .sel(sel), .tick_1hz(tick_1hz), .tick_2hz(tick_2hz),
        .min_tens(mt1), .min_ones(mo1), .sec_tens(st1), .sec_ones(so1),
        .blank_mask(bm1), .running(run1)
    );

    // Packed view {MM tens, MM ones, SS tens, SS ones, blank_mask, running}.
    function automatic logic [18:0] e(input int mm, input int ss, input logic [1:0] b, input logic r);
        return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10), b, r};
    endfunction

    typedef struct {
        logic        p, r, a, s, t1, t2;
        logic [18:0] exp;
        string       name;
    } vec_t;

    function automatic vec_t mk(input string n, input logic p, r, a, s, t1, t2,
                                input int mm, input int ss, input logic [1:0] b, input logic run);
        vec_t v;
        v.name = n; v.p = p; v.r = r; v.a = a; v.s = s; v.t1 = t1; v.t2 = t2;
        v.exp = e(mm, ss, b, run);
        return v;
    endfunction

    task automatic chk(input string n, input logic [18:0] act, input logic [18:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d%0d:%0d%0d blank=%b run=%b, want %0d%0d:%0d%0d blank=%b run=%b",
                     n, act[18:15], act[14:11], act[10:7], act[6:3], act[2:1], act[0],
                     exp[18:15], exp[14:11], exp[10:7], exp[6:3], exp[2:1], exp[0]);
        end
    endtask

    // One clock cycle with the given inputs; pulses are dropped right after the edge.
    task automatic cyc(input logic p, r, a, s, t1, t2);
        @(negedge clk);
        pause_pulse = p; reset_pulse = r; adj = a; sel = s; tick_1hz = t1; tick_2hz = t2;
        @(posedge clk);
        #1;
        pause_pulse = 1'b0; reset_pulse = 1'b0; tick_1hz = 1'b0; tick_2hz = 1'b0;
    endtask

    task automatic t1n(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, adj, sel, 1'b1, 1'b0);
    endtask

    task automatic t2n(input logic s, input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b1, s, 1'b0, 1'b1);
    endtask

    logic [18:0] a0, a1;
    always_comb a0 = {mt0, mo0, st0, so0, bm0, run0};
    always_comb a1 = {mt1, mo1, st1, so1, bm1, run1};

    vec_t vecs[$];

    initial begin
        //              name        p  r  a  s  t1 t2  MM SS blank run
        vecs.push_back(mk("idle",    0, 0, 0, 0, 0, 0,  0, 0, 2'b00, 0));
        vecs.push_back(mk("start",   1, 0, 0, 0, 0, 0,  0, 0, 2'b00, 1));
        vecs.push_back(mk("tick1",   0, 0, 0, 0, 1, 0,  0, 1, 2'b00, 1));
        vecs.push_back(mk("tick2",   0, 0, 0, 0, 1, 0,  0, 2, 2'b00, 1));
        vecs.push_back(mk("tick3",   0, 0, 0, 0, 1, 0,  0, 3, 2'b00, 1));
        vecs.push_back(mk("pause",   1, 0, 0, 0, 0, 0,  0, 3, 2'b00, 0));
        vecs.push_back(mk("hold1hz", 0, 0, 0, 0, 1, 0,  0, 3, 2'b00, 0));
        vecs.push_back(mk("hold2hz", 0, 0, 0, 0, 0, 1,  0, 3, 2'b00, 0));
        vecs.push_back(mk("adjin",   0, 0, 1, 1, 0, 0,  0, 3, 2'b00, 0));
        vecs.push_back(mk("adjsec",  0, 0, 1, 1, 0, 1,  0, 4, 2'b01, 0));
        vecs.push_back(mk("adj1hz",  0, 0, 1, 1, 1, 0,  0, 4, 2'b01, 0));
        vecs.push_back(mk("selchg",  0, 0, 1, 0, 0, 0,  0, 4, 2'b10, 0));
        vecs.push_back(mk("adjmin",  0, 0, 1, 0, 0, 1,  1, 4, 2'b00, 0));
        vecs.push_back(mk("adjpaus", 1, 0, 1, 0, 0, 0,  1, 4, 2'b00, 0));
        vecs.push_back(mk("adjexit", 0, 0, 0, 0, 0, 0,  1, 4, 2'b00, 1));
        vecs.push_back(mk("run5",    0, 0, 0, 0, 1, 0,  1, 5, 2'b00, 1));
        vecs.push_back(mk("tickpau", 1, 0, 0, 0, 1, 0,  1, 6, 2'b00, 0));

        #3;
        chk("rst_state0", a0, e(0, 0, 2'b00, 1'b0));
        chk("rst_state1", a1, e(0, 0, 2'b00, 1'b0));
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
            cyc(vecs[i].p, vecs[i].r, vecs[i].a, vecs[i].s, vecs[i].t1, vecs[i].t2);
            chk({vecs[i].name, "_0"}, a0, vecs[i].exp);
            chk({vecs[i].name, "_1"}, a1, vecs[i].exp);
        end

        // Minute carry and full wrap
        cyc(0, 1, 0, 0, 0, 0);
        chk("rstpulse", a0, e(0, 0, 2'b00, 1'b0));
        cyc(1, 0, 0, 0, 0, 0);
        t1n(59);
        chk("ss59", a0, e(0, 59, 2'b00, 1'b1));
        t1n(1);
        chk("carry", a0, e(1, 0, 2'b00, 1'b1));
        cyc(0, 0, 1, 0, 0, 0);
        t2n(1'b0, 58);
        t2n(1'b1, 59);
        cyc(0, 0, 0, 0, 0, 0);
        chk("load5959", a0, e(59, 59, 2'b00, 1'b1));
        t1n(1);
        chk("fullwrap", a0, e(0, 0, 2'b00, 1'b1));

        // Seconds adjust wraps without carrying into minutes
        t1n(58);
        chk("ss58", a0, e(0, 58, 2'b00, 1'b1));
        cyc(0, 0, 1, 1, 0, 0);
        chk("adjentry", a0, e(0, 58, 2'b00, 1'b0));
        t2n(1'b1, 1);
        chk("adj_a", a0, e(0, 59, 2'b01, 1'b0));
        t2n(1'b1, 1);
        chk("adj_b", a0, e(0, 0, 2'b00, 1'b0));
        t2n(1'b1, 1);
        chk("adj_c", a0, e(0, 1, 2'b01, 1'b0));
        cyc(0, 0, 1, 1, 1, 0);
        chk("adj_1hz", a0, e(0, 1, 2'b01, 1'b0));

        // Minutes adjust wraps 59 -> 00 leaving seconds alone; exit resumes running
        t2n(1'b1, 9);
        t2n(1'b0, 59);
        chk("mm59", a0, e(59, 10, 2'b10, 1'b0));
        t2n(1'b0, 1);
        chk("mmwrap", a0, e(0, 10, 2'b00, 1'b0));
        cyc(0, 0, 0, 0, 0, 0);
        chk("adjexit_run", a0, e(0, 10, 2'b00, 1'b1));

        // reset_pulse beats tick_1hz; PAUSE_ON_RESET variants
        cyc(0, 0, 1, 0, 0, 0);
        t2n(1'b0, 12);
        t2n(1'b1, 24);
        cyc(0, 0, 0, 0, 0, 0);
        chk("t1234_0", a0, e(12, 34, 2'b00, 1'b1));
        chk("t1234_1", a1, e(12, 34, 2'b00, 1'b1));
        cyc(0, 1, 0, 0, 1, 0);
        chk("rsttick_0", a0, e(0, 0, 2'b00, 1'b1));
        chk("rsttick_1", a1, e(0, 0, 2'b00, 1'b0));

        // Async reset between edges
        cyc(0, 0, 1, 0, 0, 0);
        t2n(1'b0, 5);
        t2n(1'b1, 7);
        cyc(0, 0, 0, 0, 0, 0);
        chk("t0507", a0, e(5, 7, 2'b00, 1'b1));
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("async_0", a0, e(0, 0, 2'b00, 1'b0));
        chk("async_1", a1, e(0, 0, 2'b00, 1'b0));
        @(negedge clk);
        rst = 1'b0;
        cyc(0, 0, 0, 0, 1, 0);
        chk("post_rst", a0, e(0, 0, 2'b00, 1'b0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
